// File: rtl/parallel_port_arbiter.sv
// Round-robin arbiter sharing one strobed 8-bit parallel receiver among NUM_REQ requesters.
// Optional ack timeout abort is enabled by defining PARALLEL_ARB_TIMEOUT_EN.
module parallel_port_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [NUM_REQ-1:0]   o_done,
    output logic                 o_err,
    output logic                 o_busy,
    output logic [7:0]           o_p_data,
    output logic                 o_p_stb,
    input  logic                 i_p_ack,
    input  logic                 i_p_rdy
);

    localparam int unsigned IDX_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StStrobe,
        StComplete
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_win;

    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_onehot;
    logic [7:0]         w_data;
    logic [PTR_W-1:0]   w_ptr_adv;

    // Scan requesters starting at r_ptr, wrapping at NUM_REQ-1; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + IDX_W'(k);
            if (w_idx >= IDX_W'(NUM_REQ)) begin
                w_idx = w_idx - IDX_W'(NUM_REQ);
            end
            if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_onehot  = NUM_REQ'(1) << w_win;
        w_data    = i_req_data[{w_win, 3'b000} +: 8];
        w_ptr_adv = (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + PTR_W'(1);
    end

`ifdef PARALLEL_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [15:0] r_timer;
    logic [15:0] w_timer_nxt;

    assign w_timer_nxt = r_timer + 16'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_ptr    <= '0;
            r_win    <= '0;
            r_timer  <= '0;
            o_grant  <= '0;
            o_done   <= '0;
            o_err    <= 1'b0;
            o_busy   <= 1'b0;
            o_p_data <= 8'h00;
            o_p_stb  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found && i_p_rdy) begin
                        r_win    <= w_win;
                        r_timer  <= '0;
                        o_grant  <= w_onehot;
                        o_p_data <= w_data;
                        o_p_stb  <= 1'b1;
                        o_busy   <= 1'b1;
                        r_state  <= StStrobe;
                    end
                end
                StStrobe: begin
                    r_timer <= w_timer_nxt;
                    // Ack on the same edge as expiry counts as a clean completion.
                    if (i_p_ack || (w_timer_nxt == TIMEOUT_CNT)) begin
                        o_p_stb <= 1'b0;
                        o_grant <= '0;
                        o_done  <= o_grant;
                        o_err   <= ~i_p_ack;
                        r_ptr   <= w_ptr_adv;
                        r_state <= StComplete;
                    end
                end
                StComplete: begin
                    o_done  <= '0;
                    o_err   <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT == 0);
    assign o_err            = 1'b0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_ptr    <= '0;
            r_win    <= '0;
            o_grant  <= '0;
            o_done   <= '0;
            o_busy   <= 1'b0;
            o_p_data <= 8'h00;
            o_p_stb  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found && i_p_rdy) begin
                        r_win    <= w_win;
                        o_grant  <= w_onehot;
                        o_p_data <= w_data;
                        o_p_stb  <= 1'b1;
                        o_busy   <= 1'b1;
                        r_state  <= StStrobe;
                    end
                end
                StStrobe: begin
                    if (i_p_ack) begin
                        o_p_stb <= 1'b0;
                        o_grant <= '0;
                        o_done  <= o_grant;
                        r_ptr   <= w_ptr_adv;
                        r_state <= StComplete;
                    end
                end
                StComplete: begin
                    o_done  <= '0;
                    o_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_parallel_port_arbiter.sv
// Directed self-checking bench for parallel_port_arbiter (NUM_REQ=4, TIMEOUT=4).
// Timeout scenario runs only when PARALLEL_ARB_TIMEOUT_EN is defined.
module tb_parallel_port_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic [7:0]  p_data;
    logic        p_stb;
    logic        p_ack;
    logic        p_rdy;

    int n_checks = 0;
    int n_fails  = 0;

    parallel_port_arbiter #(
        .NUM_REQ (4),
        .TIMEOUT (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_req_data (req_data),
        .o_grant    (grant),
        .o_done     (done),
        .o_err      (err),
        .o_busy     (busy),
        .o_p_data   (p_data),
        .o_p_stb    (p_stb),
        .i_p_ack    (p_ack),
        .i_p_rdy    (p_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant edge, ack_delay hold cycles, ack edge, then the done cycle.
    task automatic do_xfer(input string tag, input int w, input logic [7:0] d, input int ack_delay);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        step();
        check({tag, " grant"}, 32'(grant), 32'(oh));
        check({tag, " p_data"}, 32'(p_data), 32'(d));
        check({tag, " stb"}, 32'(p_stb), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < ack_delay; i++) begin
            step();
            check({tag, " stb hold"}, 32'(p_stb), 32'd1);
            check({tag, " grant hold"}, 32'(grant), 32'(oh));
        end
        p_ack = 1'b1;
        step();
        p_ack = 1'b0;
        check({tag, " done"}, 32'(done), 32'(oh));
        check({tag, " grant clr"}, 32'(grant), 32'd0);
        check({tag, " stb clr"}, 32'(p_stb), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        req[w] = 1'b0;
        step();
        check({tag, " done 1cyc"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        p_ack    = 1'b0;
        p_rdy    = 1'b0;
        step();
        step();
        check("rst grant", 32'(grant), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst p_data", 32'(p_data), 32'h00);
        check("rst stb", 32'(p_stb), 32'd0);
        rst = 1'b0;

        // Single requester 2, ack two cycles after strobe.
        req   = 4'b0100;
        p_rdy = 1'b1;
        do_xfer("t1", 2, 8'hA5, 1);

        // Pointer now 3: requester 3 beats requester 0.
        req = 4'b1001;
        do_xfer("t1 ptr3", 3, 8'h44, 0);
        check("t1 req0 pending", 32'(grant), 32'd0);

        // All request; round robin from ptr 0 (req0 still high from above).
        req = 4'b1111;
        do_xfer("t2 r0", 0, 8'h11, 0);
        do_xfer("t2 r1", 1, 8'h22, 0);
        do_xfer("t2 r2", 2, 8'hA5, 0);
        do_xfer("t2 r3", 3, 8'h44, 0);

        // Receiver not ready: nothing granted.
        req   = 4'b0001;
        p_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3 no stb", 32'(p_stb), 32'd0);
            check("t3 no busy", 32'(busy), 32'd0);
        end
        p_rdy = 1'b1;
        do_xfer("t3 rdy", 0, 8'h11, 0);

        // Data and request change during strobe are ignored.
        req = 4'b0001;
        step();
        check("t4 grant", 32'(grant), 32'b0001);
        check("t4 p_data", 32'(p_data), 32'h11);
        req_data[7:0] = 8'hEE;
        req           = 4'b0000;
        step();
        check("t4 data held", 32'(p_data), 32'h11);
        check("t4 stb held", 32'(p_stb), 32'd1);
        p_ack = 1'b1;
        step();
        p_ack = 1'b0;
        check("t4 done", 32'(done), 32'b0001);
        step();
        check("t4 done clr", 32'(done), 32'd0);
        req_data[7:0] = 8'h11;

        // Async reset mid-strobe drops everything, no done, ptr back to 0.
        req = 4'b0010;
        step();
        check("t5 grant", 32'(grant), 32'b0010);
        #2 rst = 1'b1;
        #1;
        check("t5 async stb", 32'(p_stb), 32'd0);
        check("t5 async grant", 32'(grant), 32'd0);
        check("t5 async busy", 32'(busy), 32'd0);
        req = 4'b0011;
        step();
        check("t5 no done", 32'(done), 32'd0);
        rst = 1'b0;
        do_xfer("t5 ptr0", 0, 8'h11, 0);
        do_xfer("t5 r1", 1, 8'h22, 0);

`ifdef PARALLEL_ARB_TIMEOUT_EN
        // Pointer is 2; requester 2 never acked, aborts after 4 strobe cycles.
        req = 4'b0101;
        step();
        check("t6 grant", 32'(grant), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6 stb", 32'(p_stb), 32'd1);
            check("t6 no err", 32'(err), 32'd0);
        end
        step();
        check("t6 done", 32'(done), 32'b0100);
        check("t6 err", 32'(err), 32'd1);
        check("t6 stb clr", 32'(p_stb), 32'd0);
        req[2] = 1'b0;
        step();
        check("t6 err clr", 32'(err), 32'd0);
        check("t6 done clr", 32'(done), 32'd0);
        do_xfer("t6 next", 0, 8'h11, 0);
`else
        // err is constant low without the timeout feature, even under a long stall.
        req = 4'b0100;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            check("t6 stall stb", 32'(p_stb), 32'd1);
            check("t6 stall err", 32'(err), 32'd0);
        end
        p_ack = 1'b1;
        step();
        p_ack = 1'b0;
        check("t6 late done", 32'(done), 32'b0100);
        check("t6 late err", 32'(err), 32'd0);
        req = 4'b0000;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
